arp_req_arbiter: RTL and testbench

//  Shares the single ARP-module lookup port (arp_request_*/arp_response_*) among NUM_PORTS IP-layer requesters.

---
 rtl/arp_arb_pkg.sv | 8 +
 rtl/rr_picker.sv | 30 +++
 rtl/arp_req_arbiter.sv | 132 +++++++++++++
 tb/tb_arp_req_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_arb_pkg.sv
// rtl/arp_arb_pkg.sv - shared types and widths for the ARP lookup arbiter
package arp_arb_pkg;
  localparam int IP_W  = 32;
  localparam int MAC_W = 48;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT_RESP, ARB_RESP} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the first active request at or after ptr
module rr_picker #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic                         valid,
  output logic [$clog2(NUM_PORTS)-1:0] idx
);
  localparam int PW = $clog2(NUM_PORTS);

  // Walk the ring backwards so the last hit written is the one nearest ptr.
  always_comb begin
    int j;
    logic [PW-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    cand  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      cand = PW'(j);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/arp_req_arbiter.sv
// rtl/arp_req_arbiter.sv - round-robin sharing of the ARP lookup port; optional watchdog under ARB_TIMEOUT_EN
module arp_req_arbiter
  import arp_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         s_req_valid,
  output logic [NUM_PORTS-1:0]         s_req_ready,
  input  logic [NUM_PORTS*IP_W-1:0]    s_req_ip,
  output logic [NUM_PORTS-1:0]         s_resp_valid,
  input  logic [NUM_PORTS-1:0]         s_resp_ready,
  output logic                         s_resp_error,
  output logic [MAC_W-1:0]             s_resp_mac,
  output logic                         arp_request_valid,
  input  logic                         arp_request_ready,
  output logic [IP_W-1:0]              arp_request_ip,
  input  logic                         arp_response_valid,
  output logic                         arp_response_ready,
  input  logic                         arp_response_error,
  input  logic [MAC_W-1:0]             arp_response_mac,
  output logic                         busy,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic [CNT_W-1:0]             stale_drop_cnt
);
  localparam int PW = $clog2(NUM_PORTS);

  arb_state_t    state, state_n;
  logic [PW-1:0] rr_ptr;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          timeout_hit;
  logic          stale;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req   (s_req_valid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt;

  // Held at zero outside WAIT_RESP, so every wait starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         to_cnt <= '0;
    else if (state != ARB_WAIT_RESP) to_cnt <= '0;
    else                             to_cnt <= to_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == ARB_WAIT_RESP) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  // Handshake outputs are forced low while rst is held.
  always_comb begin
    state_n            = state;
    s_req_ready        = '0;
    s_resp_valid       = '0;
    arp_request_valid  = 1'b0;
    arp_response_ready = 1'b0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          arp_response_ready = 1'b1;
          if (pick_valid) begin
            s_req_ready[pick_idx] = 1'b1;
            state_n = ARB_REQ;
          end
        end
        ARB_REQ: begin
          arp_request_valid  = 1'b1;
          arp_response_ready = 1'b1;
          if (arp_request_ready) state_n = ARB_WAIT_RESP;
        end
        ARB_WAIT_RESP: begin
          arp_response_ready = 1'b1;
          if (arp_response_valid || timeout_hit) state_n = ARB_RESP;
        end
        ARB_RESP: begin
          s_resp_valid[grant_id] = 1'b1;
          if (s_resp_ready[grant_id]) state_n = ARB_IDLE;
        end
        default: state_n = ARB_IDLE;
      endcase
    end
  end

  assign stale = arp_response_valid && arp_response_ready &&
                 (state == ARB_IDLE || state == ARB_REQ);
  assign busy  = (state != ARB_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      grant_id       <= '0;
      arp_request_ip <= '0;
      s_resp_mac     <= '0;
      s_resp_error   <= 1'b0;
      stale_drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (stale && stale_drop_cnt != '1) stale_drop_cnt <= stale_drop_cnt + CNT_W'(1);
      case (state)
        ARB_IDLE: if (pick_valid) begin
          grant_id       <= pick_idx;
          arp_request_ip <= s_req_ip[int'(pick_idx)*IP_W +: IP_W];
        end
        ARB_WAIT_RESP: begin
          if (arp_response_valid) begin
            s_resp_mac   <= arp_response_mac;
            s_resp_error <= arp_response_error;
          end else if (timeout_hit) begin
            s_resp_mac   <= '0;
            s_resp_error <= 1'b1;
          end
        end
        ARB_RESP: if (s_resp_ready[grant_id]) begin
          rr_ptr <= (grant_id == PW'(NUM_PORTS - 1)) ? '0 : grant_id + PW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arp_req_arbiter.sv
// tb/tb_arp_req_arbiter.sv - randomized self-checking bench with a round-robin reference model
module tb_arp_req_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [N*32-1:0] s_req_ip;
  logic          s_resp_error;
  logic [47:0]   s_resp_mac;
  logic          arp_request_valid, arp_request_ready;
  logic [31:0]   arp_request_ip;
  logic          arp_response_valid, arp_response_ready, arp_response_error;
  logic [47:0]   arp_response_mac;
  logic          busy;
  logic [1:0]    grant_id;
  logic [15:0]   stale_drop_cnt;

  arp_req_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_ip(s_req_ip),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_resp_error(s_resp_error), .s_resp_mac(s_resp_mac),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .busy(busy), .grant_id(grant_id), .stale_drop_cnt(stale_drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [N-1:0] pend;
  logic [31:0] ips [N];
  int          ptr_m;
  int          stale_m;
  int          order [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++)
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_req(input logic [N-1:0] bits);
    for (int k = 0; k < N; k++)
      if (bits[k] && !pend[k]) begin
        ips[k] = $urandom;
        s_req_ip[32*k +: 32] = ips[k];
      end
    pend = pend | bits;
  endtask

  // One complete grant: accept, hold the ARP request, wait, reply, hold the response.
  task automatic do_txn(input int hreq, input int dresp, input int hresp,
                        input logic [47:0] mac, input logic err, input logic stale_idle);
    int w;
    logic [N-1:0] oh;
    w  = pick(pend, ptr_m);
    oh = N'(1) << w;
    order.push_back(w);
    s_req_valid = pend;
    arp_response_valid = stale_idle;
    arp_response_mac   = 48'hDEAD_BEEF_0000;
    #1;
    chk("req_ready", s_req_ready, oh);
    chk("idle_busy", busy, 0);
    tick();
    arp_response_valid = 1'b0;
    if (stale_idle) stale_m++;
    pend[w] = 1'b0;
    s_req_valid = pend;
    chk("grant_id", grant_id, w);
    for (int i = 0; i < hreq; i++) begin
      chk("req_hold_valid", arp_request_valid, 1);
      chk("req_hold_ip", arp_request_ip, ips[w]);
      chk("req_ready_busy", s_req_ready, 0);
      tick();
    end
    arp_request_ready = 1'b1;
    #1;
    chk("req_valid", arp_request_valid, 1);
    chk("req_ip", arp_request_ip, ips[w]);
    tick();
    arp_request_ready = 1'b0;
    for (int i = 0; i < dresp; i++) begin
      chk("wait_no_resp", s_resp_valid, 0);
      tick();
    end
    arp_response_valid = 1'b1;
    arp_response_mac   = mac;
    arp_response_error = err;
    #1;
    chk("arp_resp_ready", arp_response_ready, 1);
    tick();
    arp_response_valid = 1'b0;
    arp_response_mac   = {$urandom, $urandom};
    arp_response_error = 1'b0;
    for (int i = 0; i <= hresp; i++) begin
      s_resp_ready = N'($urandom) & ~oh;
      if (i == hresp) s_resp_ready = s_resp_ready | oh;
      #1;
      chk("resp_valid", s_resp_valid, oh);
      chk("resp_mac", s_resp_mac, mac);
      chk("resp_err", s_resp_error, err);
      chk("resp_no_ready", arp_response_ready, 0);
      tick();
    end
    s_resp_ready = '0;
    ptr_m = (w + 1) % N;
    chk("resp_done", s_resp_valid, 0);
    chk("stale_cnt", stale_drop_cnt, stale_m);
  endtask

  initial begin
    int w;
    logic [N-1:0] oh;
    rst = 1'b1;
    pend = '0;
    s_req_valid = '0; s_req_ip = '0; s_resp_ready = '0;
    arp_request_ready = 1'b0; arp_response_valid = 1'b0;
    arp_response_error = 1'b0; arp_response_mac = '0;
    ptr_m = 0; stale_m = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ip", arp_request_ip, 0);
    chk("rst_arp_rsp_rdy", arp_response_ready, 0);
    chk("rst_mac", s_resp_mac, 0);
    chk("rst_stale", stale_drop_cnt, 0);
    rst = 1'b0;
    #1;
    chk("idle_arp_rsp_rdy", arp_response_ready, 1);
    chk("idle_req_valid", arp_request_valid, 0);
    tick();

    // Three simultaneous requesters, then 0 and 3 with the pointer past 2.
    add_req(4'b0111);
    for (int i = 0; i < 3; i++) do_txn(0, 1, 0, {$urandom, $urandom}, 1'b0, 1'b0);
    add_req(4'b1001);
    for (int i = 0; i < 2; i++) do_txn(0, 0, 0, {$urandom, $urandom}, 1'b0, 1'b0);
    chk("order_len", order.size(), 5);
    chk("order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]},
        20'h01230);

    // Minimum latency, then an error reply, then long back-pressure on both sides.
    pend = 4'b0001; ips[0] = 32'hC0A80164; s_req_ip[31:0] = ips[0];
    do_txn(0, 0, 0, 48'h5A5152535455, 1'b0, 1'b0);
    add_req(4'b0010);
    do_txn(0, 2, 0, {$urandom, $urandom}, 1'b1, 1'b0);
    add_req(4'b0101);
    do_txn(10, 1, 5, {$urandom, $urandom}, 1'b0, 1'b0);

    // Request acceptance and a response in the same REQ cycle: the response is stale.
    w = pick(pend, ptr_m); oh = N'(1) << w;
    s_req_valid = pend;
    tick();
    pend[w] = 1'b0; s_req_valid = pend;
    arp_request_ready = 1'b1; arp_response_valid = 1'b1; arp_response_mac = 48'h111111111111;
    tick();
    arp_request_ready = 1'b0; arp_response_valid = 1'b0;
    stale_m++;
    chk("req_stale_cnt", stale_drop_cnt, stale_m);
    chk("req_stale_wait", s_resp_valid, 0);
    arp_response_valid = 1'b1; arp_response_mac = 48'hA1A2A3A4A5A6;
    tick();
    arp_response_valid = 1'b0;
    chk("req_stale_resp", s_resp_valid, oh);
    chk("req_stale_mac", s_resp_mac, 48'hA1A2A3A4A5A6);
    s_resp_ready = oh;
    tick();
    s_resp_ready = '0;
    ptr_m = (w + 1) % N;

    // Randomized traffic with occasional stale responses in IDLE.
    for (int it = 0; it < 40; it++) begin
      add_req(N'($urandom) | ((pend == 0) ? N'(1) << $urandom_range(N - 1) : '0));
      do_txn($urandom_range(3), $urandom_range(3), $urandom_range(3),
             {$urandom, $urandom} | 48'h1, 1'($urandom), ($urandom_range(3) == 0));
    end

`ifdef ARB_TIMEOUT_EN
    add_req(4'b1000);
    w = pick(pend, ptr_m); oh = N'(1) << w;
    s_req_valid = pend;
    tick();
    pend[w] = 1'b0; s_req_valid = pend;
    arp_request_ready = 1'b1;
    tick();
    arp_request_ready = 1'b0;
    for (int k = 1; k < 16; k++) tick();
    chk("to_before", s_resp_valid, 0);
    tick();
    chk("to_valid", s_resp_valid, oh);
    chk("to_err", s_resp_error, 1);
    chk("to_mac", s_resp_mac, 0);
    s_resp_ready = oh;
    tick();
    s_resp_ready = '0;
    ptr_m = (w + 1) % N;
    tick(); tick(); tick();
    arp_response_valid = 1'b1;
    tick();
    arp_response_valid = 1'b0;
    stale_m++;
    chk("to_late_stale", stale_drop_cnt, stale_m);
`endif

    // Make the pointer land on 3, then reset mid-lookup and expect port 0 first.
    pend = '0; s_req_valid = '0;
    add_req(4'b0100);
    do_txn(0, 0, 0, 48'hFEDCBA987654, 1'b1, 1'b1);
    add_req(4'b0010);
    s_req_valid = pend;
    tick();
    pend = '0; s_req_valid = '0;
    arp_request_ready = 1'b1;
    tick();
    arp_request_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_ip", arp_request_ip, 0);
    chk("mid_rst_mac", s_resp_mac, 0);
    chk("mid_rst_err", s_resp_error, 0);
    chk("mid_rst_stale", stale_drop_cnt, 0);
    chk("mid_rst_rsp_rdy", arp_response_ready, 0);
    tick();
    rst = 1'b0;
    ptr_m = 0; stale_m = 0;
    add_req(4'b1011);
    do_txn(0, 0, 0, {$urandom, $urandom}, 1'b0, 1'b0);
    chk("post_rst_grant", order[order.size() - 1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
